fpu_addsub_ctrl: RTL and testbench

Sequencing front/back end for the combinational floating-point add/subtract unit. Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake, buffers them in a small FIFO, and presents the head entry to the adder on dedicated ports. It registers the adder's result together with a tag and status flags, then returns it over a second valid/ready handshake. It sits between the FPU issue logic and the result writeback path.

---
 rtl/fpu_addsub_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fpu_addsub_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_ctrl.sv
// fpu_addsub_ctrl: sequencing shell around a combinational single-precision
// floating-point add/subtract unit.
//   - Operand pairs enter over a valid/ready handshake into a circular FIFO.
//   - The FIFO head is presented to the external adder on the as_* ports.
//   - The adder result is registered with its tag and two status flags,
//     then returned over a second valid/ready handshake.
// Optional feature: define FPU_ADDSUB_STATS_EN to build the 16-bit
// completed-operation counter on op_count. Without it, op_count is tied to 0.
module fpu_addsub_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic                       in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [31:0]                as_a,
    output logic [31:0]                as_b,
    output logic                       as_addsub,
    input  logic [31:0]                as_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_zero,
    output logic                       out_exp_max,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Magnitude bits all zero: covers both +0 and -0.
    function automatic logic flag_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction

    // Exponent saturated: Inf or NaN, i.e. the add overflowed or an operand was special.
    function automatic logic flag_exp_max(input logic [31:0] v);
        return (v[30:23] == 8'hFF);
    endfunction

    // FIFO storage and control
    logic [31:0]      mem_a   [DEPTH];
    logic [31:0]      mem_b   [DEPTH];
    logic             mem_op  [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             vld_p0;

    // Output register stage
    state_t           state;
    state_t           state_next;
    logic             capture;
    logic [31:0]      result_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             zero_p1;
    logic             exp_max_p1;

    logic             push;

    assign vld_p0   = (count_q != '0);
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    // ---- stage p0: FIFO head presented to the adder ----
    assign as_a      = vld_p0 ? mem_a[rd_ptr]  : 32'd0;
    assign as_b      = vld_p0 ? mem_b[rd_ptr]  : 32'd0;
    assign as_addsub = vld_p0 ? mem_op[rd_ptr] : 1'b0;

    // Write operand payload at the tail; storage needs no reset since count gates its use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_op[wr_ptr]  <= in_op;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    // FIFO pointers and occupancy; flush discards everything and ignores same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (capture) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, capture})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Output state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture decision: pop the head whenever the holding register is free or being drained.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else if (vld_p0 && (state == EMPTY || out_ready)) begin
            capture    = 1'b1;
            state_next = FULL;
        end else if (out_ready) begin
            state_next = EMPTY;
        end
    end

    // ---- stage p1: registered adder result, tag and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1  <= 32'd0;
            tag_p1     <= '0;
            zero_p1    <= 1'b0;
            exp_max_p1 <= 1'b0;
        end else if (capture) begin
            result_p1  <= as_result;
            tag_p1     <= mem_tag[rd_ptr];
            zero_p1    <= flag_zero(as_result);
            exp_max_p1 <= flag_exp_max(as_result);
        end
    end

    assign out_valid   = (state == FULL);
    assign out_result  = result_p1;
    assign out_tag     = tag_p1;
    assign out_zero    = zero_p1;
    assign out_exp_max = exp_max_p1;
    assign count       = count_q;

`ifdef FPU_ADDSUB_STATS_EN
    logic [15:0] op_count_q;

    // Count every output handshake; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 16'd0;
        end else if (out_valid && out_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Testbench for fpu_addsub_ctrl: directed vector table plus hand-written
// sequences for streaming, backpressure, flush and reset.
module tb_fpu_addsub_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic              in_op;
    logic [TAG_W-1:0]  in_tag;
    logic [31:0]       as_a;
    logic [31:0]       as_b;
    logic              as_addsub;
    logic [31:0]       as_result;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_exp_max;
    logic [2:0]        count;
    logic [15:0]       op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]      got_res[$];
    logic [TAG_W-1:0] got_tag[$];

    fpu_addsub_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .as_a(as_a), .as_b(as_b), .as_addsub(as_addsub), .as_result(as_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_zero(out_zero), .out_exp_max(out_exp_max),
        .count(count), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Adder stand-in: IEEE-754 results worked out by hand for the operands used here.
    function automatic logic [31:0] fp_stub(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [64:0] key;
        key = {a, b, op};
        case (key)
            {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000; // 1 + 2 = 3
            {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000; // 3 - 1 = 2
            {32'h7F000000, 32'h7F000000, 1'b0}: return 32'h7F800000; // overflow to +Inf
            {32'h3F800000, 32'h3F800000, 1'b1}: return 32'h00000000; // 1 - 1 = +0
            {32'h80000000, 32'h80000000, 1'b0}: return 32'h80000000; // -0 + -0 = -0
            {32'h7F800000, 32'h7F800000, 1'b1}: return 32'h7FC00000; // Inf - Inf = qNaN
            default:                            return 32'h0BAD0000;
        endcase
    endfunction

    always_comb as_result = fp_stub(as_a, as_b, as_addsub);

    // Record every output handshake for ordering checks.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_res.push_back(out_result);
            got_tag.push_back(out_tag);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] exp_ops(input int n);
`ifdef FPU_ADDSUB_STATS_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n - n);
`endif
    endfunction

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             zero;
        logic             emax;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first, last, total;
        int waited;
        logic [15:0] ops_before;

        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'h3, 32'h40400000, 1'b0, 1'b0};
        vecs[1] = '{32'h40400000, 32'h3F800000, 1'b1, 4'h5, 32'h40000000, 1'b0, 1'b0};
        vecs[2] = '{32'h7F000000, 32'h7F000000, 1'b0, 4'h7, 32'h7F800000, 1'b0, 1'b1};
        vecs[3] = '{32'h3F800000, 32'h3F800000, 1'b1, 4'h9, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 4'hA, 32'h80000000, 1'b1, 1'b0};
        vecs[5] = '{32'h7F800000, 32'h7F800000, 1'b1, 4'hF, 32'h7FC00000, 1'b0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
        do_reset();

        // Reset state
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_result", out_result,     32'd0);
        check("rst_out_tag",   32'(out_tag),    32'd0);
        check("rst_flags",     32'({out_zero, out_exp_max}), 32'd0);
        check("rst_count",     32'(count),      32'd0);
        check("rst_op_count",  32'(op_count),   32'd0);
        check("rst_as_a",      as_a,            32'd0);

        // Table-driven single operations: accept at edge k, result visible after k+1.
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_count1", i), 32'(count), 32'd1);
            check($sformatf("v%0d_vld_early", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_as_a", i), as_a, vecs[i].a);
            check($sformatf("v%0d_as_b", i), as_b, vecs[i].b);
            check($sformatf("v%0d_as_op", i), 32'(as_addsub), 32'(vecs[i].op));
            tick();
            check($sformatf("v%0d_vld", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_res", i), out_result, vecs[i].res);
            check($sformatf("v%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
            check($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].zero));
            check($sformatf("v%0d_emax", i), 32'(out_exp_max), 32'(vecs[i].emax));
            check($sformatf("v%0d_count0", i), 32'(count), 32'd0);
            check($sformatf("v%0d_as_a_empty", i), as_a, 32'd0);
            out_ready = 1'b1;
            tick();
            check($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
            out_ready = 1'b0;
        end
        check("ops_after_table", 32'(op_count), 32'(exp_ops(6)));

        // Streaming: 8 subtracts back to back with out_ready high.
        got_res.delete(); got_tag.delete();
        out_ready = 1'b1;
        first = -1; last = -1; total = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 8) drive_req(32'h40400000, 32'h3F800000, 1'b1, TAG_W'(cyc));
            else in_valid = 1'b0;
            tick();
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                total++;
            end
        end
        check("stream_valid_cycles", 32'(total), 32'd8);
        check("stream_contiguous", 32'(last - first), 32'd7);
        check("stream_first_cycle", 32'(first), 32'd1);
        check("stream_hs_count", 32'(got_tag.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_tag.size()) begin
                check($sformatf("stream_tag%0d", i), 32'(got_tag[i]), 32'(i));
                check($sformatf("stream_res%0d", i), got_res[i], 32'h40000000);
            end
        end
        check("ops_after_stream", 32'(op_count), 32'(exp_ops(14)));

        // Backpressure: DEPTH + 1 outstanding, then full.
        got_res.delete(); got_tag.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd1);
            drive_req(32'h3F800000, 32'h40000000, 1'b0, TAG_W'(i));
            tick();
        end
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_count", 32'(count), 32'd4);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_tag", 32'(out_tag), 32'd1);
        drive_req(32'h3F800000, 32'h40000000, 1'b0, 4'hC);
        tick();
        check("bp_reject_count", 32'(count), 32'd4);
        check("bp_held_stable", 32'(out_tag), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        check("bp_count_after_pop", 32'(count), 32'd3);
        waited = 0;
        while (got_tag.size() < 5 && waited < 20) begin
            tick();
            waited++;
        end
        check("bp_drain_count", 32'(got_tag.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_tag.size()) begin
                check($sformatf("bp_tag%0d", i), 32'(got_tag[i]), 32'(i + 1));
                check($sformatf("bp_res%0d", i), got_res[i], 32'h40400000);
            end
        end
        tick();
        check("bp_idle", 32'(out_valid), 32'd0);
        check("ops_after_bp", 32'(op_count), 32'(exp_ops(19)));

        // Flush with 3 queued and 1 held; the flush-cycle request must be dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h40400000, 32'h3F800000, 1'b1, TAG_W'(8 + i));
            tick();
        end
        in_valid = 1'b0;
        check("fl_pre_count", 32'(count), 32'd3);
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        ops_before = op_count;
        flush = 1'b1;
        drive_req(32'h3F800000, 32'h40000000, 1'b0, 4'hD);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_op_count", 32'(op_count), 32'(ops_before));
        tick();
        check("fl_no_accept_count", 32'(count), 32'd0);
        check("fl_no_accept_valid", 32'(out_valid), 32'd0);

        // Stats after reset, then reset mid-stream.
        do_reset();
        got_res.delete(); got_tag.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(32'h3F800000, 32'h40000000, 1'b0, TAG_W'(i));
            tick();
        end
        in_valid = 1'b0;
        waited = 0;
        while (got_tag.size() < 5 && waited < 20) begin
            tick();
            waited++;
        end
        check("st_hs_count", 32'(got_tag.size()), 32'd5);
        check("st_op_count", 32'(op_count), 32'(exp_ops(5)));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(32'h7F000000, 32'h7F000000, 1'b0, TAG_W'(4 + i));
            tick();
        end
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        check("mr_pre_emax", 32'(out_exp_max), 32'd1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_result", out_result, 32'd0);
        check("mr_tag", 32'(out_tag), 32'd0);
        check("mr_flags", 32'({out_zero, out_exp_max}), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_op_count", 32'(op_count), 32'd0);
        check("mr_as_a", as_a, 32'd0);
        tick();
        check("mr_stays_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
